// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store with programmable wait states.
// Optional DMEM_ALIGN_CHECK_EN faults misaligned half/word accesses.
module dmem_responder #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_mode,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(DEPTH * 4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, next;
  logic [3:0] cnt;

  logic             l_we;
  logic [1:0]       l_mode;
  logic [WIDTH-1:0] l_addr;
  logic [WIDTH-1:0] l_wdata;

  logic             accept;
  logic             enter_resp;
  logic             a_we;
  logic [1:0]       a_mode;
  logic [WIDTH-1:0] a_addr;
  logic [WIDTH-1:0] a_wdata;

  logic [AW-1:0]    idx;
  logic [1:0]       lane;
  logic [WIDTH-1:0] mask;
  logic [4:0]       sh;
  logic             bad_mode;
  logic             misalign;
  logic             rerr;
  logic [WIDTH-1:0] old;
  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] wr;

  logic [WIDTH-1:0] mem [DEPTH];

  assign accept = req_valid && req_ready;

  // With zero wait states the access uses the live request on the accept edge.
  assign enter_resp = (state == IDLE && accept && WAIT_CYCLES == 0)
                   || (state == WAIT && cnt == 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      l_we    <= 1'b0;
      l_mode  <= '0;
      l_addr  <= '0;
      l_wdata <= '0;
    end else begin
      state <= next;
      if (state == IDLE && accept) begin
        cnt     <= 4'(WAIT_CYCLES);
        l_we    <= req_we;
        l_mode  <= req_mode;
        l_addr  <= req_addr;
        l_wdata <= req_wdata;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: if (accept) next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd1) next = RESP;
      RESP: if (resp_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) && !rst;
    resp_valid = (state == RESP);
  end

  assign a_we    = (state == IDLE) ? req_we    : l_we;
  assign a_mode  = (state == IDLE) ? req_mode  : l_mode;
  assign a_addr  = (state == IDLE) ? req_addr  : l_addr;
  assign a_wdata = (state == IDLE) ? req_wdata : l_wdata;

  assign idx = a_addr[AW+1:2];

  always_comb begin
    lane     = 2'd0;
    mask     = '0;
    bad_mode = 1'b0;
    unique case (a_mode)
      2'b00: mask = '1;
      2'b01: begin
        lane = {a_addr[1], 1'b0};
        mask = WIDTH'(16'hFFFF);
      end
      2'b10: begin
        lane = a_addr[1:0];
        mask = WIDTH'(8'hFF);
      end
      default: bad_mode = 1'b1;
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = (a_mode == 2'b01 && a_addr[0])
                 || (a_mode == 2'b00 && a_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign sh   = {lane, 3'b000};
  assign rerr = bad_mode || (a_addr >= LIMIT) || misalign;
  assign old  = mem[idx];
  assign rd   = (old >> sh) & mask;
  assign wr   = (old & ~(mask << sh)) | ((a_wdata & mask) << sh);

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (enter_resp) begin
      resp_err   <= rerr;
      resp_rdata <= (rerr || a_we) ? '0 : rd;
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && a_we && !rerr) mem[idx] <= wr;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (WAIT_CYCLES=2, DEPTH=256).
// Honours DMEM_ALIGN_CHECK_EN when choosing misalignment expectations.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_mode = 2'b00;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] r;
  logic        e;
  int          lat;

  always #5 clk = ~clk;

  dmem_responder #(.WIDTH(32), .DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_mode   (req_mode),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_resp(output int l);
    l = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        l = i;
        break;
      end
    end
    chk("resp_seen", 32'(l != 0), 32'd1);
  endtask

  task automatic xfer(input logic we, input logic [1:0] mode,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err,
                      output int l);
    logic ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_mode  = mode;
    req_addr  = addr;
    req_wdata = wdata;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("req_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp(l);
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    xfer(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, r, e, lat);
    chk("st_w_lat", 32'(lat), 32'd3);
    chk("st_w_rdata", r, 32'd0);
    chk("st_w_err", 32'(e), 32'd0);
    xfer(1'b0, 2'b00, 32'h10, 32'h0, r, e, lat);
    chk("ld_w_rdata", r, 32'hDEADBEEF);
    chk("ld_w_lat", 32'(lat), 32'd3);

    xfer(1'b1, 2'b10, 32'h13, 32'h123456AA, r, e, lat);
    xfer(1'b1, 2'b01, 32'h10, 32'hFFFF1234, r, e, lat);
    xfer(1'b0, 2'b00, 32'h10, 32'h0, r, e, lat);
    chk("lanes_word", r, 32'hAAAD1234);
    xfer(1'b0, 2'b10, 32'h13, 32'h0, r, e, lat);
    chk("ld_b13", r, 32'h000000AA);
    xfer(1'b0, 2'b10, 32'h11, 32'h0, r, e, lat);
    chk("ld_b11", r, 32'h00000012);
    xfer(1'b0, 2'b01, 32'h12, 32'h0, r, e, lat);
    chk("ld_h12", r, 32'h0000AAAD);

    // Backpressure: response held while a second request waits.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_mode  = 2'b00;
    req_addr  = 32'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp(lat);
    chk("bp_lat", 32'(lat), 32'd3);
    req_valid = 1'b1;
    req_mode  = 2'b10;
    req_addr  = 32'h13;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_rdata", resp_rdata, 32'hAAAD1234);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("bp_hs_ready", 32'(req_ready), 32'd1);
    chk("bp_hs_valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp(lat);
    chk("bp2_lat", 32'(lat), 32'd3);
    chk("bp2_rdata", resp_rdata, 32'h000000AA);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);

    xfer(1'b0, 2'b00, 32'h400, 32'h0, r, e, lat);
    chk("oor_err", 32'(e), 32'd1);
    chk("oor_rdata", r, 32'd0);
    xfer(1'b1, 2'b00, 32'h0, 32'h01020304, r, e, lat);
    xfer(1'b1, 2'b00, 32'h400, 32'hFFFFFFFF, r, e, lat);
    chk("oor_st_err", 32'(e), 32'd1);
    xfer(1'b0, 2'b00, 32'h0, 32'h0, r, e, lat);
    chk("oor_no_write", r, 32'h01020304);

    xfer(1'b1, 2'b00, 32'h14, 32'hCAFEF00D, r, e, lat);
    xfer(1'b0, 2'b11, 32'h14, 32'h0, r, e, lat);
    chk("m11_ld_err", 32'(e), 32'd1);
    chk("m11_ld_rdata", r, 32'd0);
    xfer(1'b1, 2'b11, 32'h14, 32'h0, r, e, lat);
    chk("m11_st_err", 32'(e), 32'd1);
    xfer(1'b0, 2'b00, 32'h14, 32'h0, r, e, lat);
    chk("m11_no_write", r, 32'hCAFEF00D);

    xfer(1'b1, 2'b00, 32'h12, 32'h11223344, r, e, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("align_err", 32'(e), 32'd1);
    xfer(1'b0, 2'b00, 32'h10, 32'h0, r, e, lat);
    chk("align_word", r, 32'hAAAD1234);
`else
    chk("align_err", 32'(e), 32'd0);
    xfer(1'b0, 2'b00, 32'h10, 32'h0, r, e, lat);
    chk("align_word", r, 32'h11223344);
`endif

    // Reset while a store sits in WAIT must drop it.
    xfer(1'b1, 2'b00, 32'h20, 32'h600DF00D, r, e, lat);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_mode  = 2'b00;
    req_addr  = 32'h20;
    req_wdata = 32'h00000055;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rstmid_valid", 32'(resp_valid), 32'd0);
    end
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    xfer(1'b0, 2'b00, 32'h20, 32'h0, r, e, lat);
    chk("rstmid_mem", r, 32'h600DF00D);
    chk("rstmid_err", 32'(e), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
